// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access function codes,
// controller states and the lane-select / extend helpers.
package mem_pkg;

    localparam logic [2:0] FUNC_BS = 3'b000;
    localparam logic [2:0] FUNC_HS = 3'b001;
    localparam logic [2:0] FUNC_WD = 3'b010;
    localparam logic [2:0] FUNC_BU = 3'b100;
    localparam logic [2:0] FUNC_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } memState_t;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } accessSize_t;

    // Any code that is not a byte or halfword function is a word access.
    function automatic accessSize_t decodeSize(input logic [2:0] func);
        accessSize_t size;
        case (func)
            FUNC_BS, FUNC_BU: size = SIZE_BYTE;
            FUNC_HS, FUNC_HU: size = SIZE_HALF;
            default:          size = SIZE_WORD;
        endcase
        return size;
    endfunction

    function automatic logic isSignedLoad(input logic [2:0] func);
        return (func == FUNC_BS) || (func == FUNC_HS);
    endfunction

    function automatic logic [3:0] laneEnables(input logic [2:0] func, input logic [1:0] addrLo);
        logic [3:0] enables;
        case (decodeSize(func))
            SIZE_BYTE: enables = 4'b0001 << addrLo;
            SIZE_HALF: enables = addrLo[1] ? 4'b1100 : 4'b0011;
            default:   enables = 4'b1111;
        endcase
        return enables;
    endfunction

    // Replicate the store operand so it lines up with whichever lanes are enabled.
    function automatic logic [31:0] storeLanes(input logic [2:0] func, input logic [31:0] data);
        logic [31:0] lanes;
        case (decodeSize(func))
            SIZE_BYTE: lanes = {4{data[7:0]}};
            SIZE_HALF: lanes = {2{data[15:0]}};
            default:   lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] loadExtend(input logic [2:0] func, input logic [1:0] addrLo,
                                               input logic [31:0] word);
        logic [7:0]  laneByte;
        logic [15:0] laneHalf;
        logic [31:0] result;
        laneByte = word[{addrLo, 3'b000} +: 8];
        laneHalf = addrLo[1] ? word[31:16] : word[15:0];
        case (decodeSize(func))
            SIZE_BYTE: result = isSignedLoad(func) ? {{24{laneByte[7]}}, laneByte} : {24'b0, laneByte};
            SIZE_HALF: result = isSignedLoad(func) ? {{16{laneHalf[15]}}, laneHalf} : {16'b0, laneHalf};
            default:   result = word;
        endcase
        return result;
    endfunction

    function automatic logic isMisaligned(input logic [2:0] func, input logic [1:0] addrLo);
        logic bad;
        case (decodeSize(func))
            SIZE_HALF: bad = addrLo[0];
            SIZE_WORD: bad = |addrLo;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_bank.sv
// Word-organised synchronous RAM, one byte-wide array per lane so each lane
// infers its own block RAM with a registered read port. Contents are not reset.
module mem_bank #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rdEn,
    input  logic                 wrEn,
    input  logic [3:0]           byteEn,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wrData,
    output logic [31:0]          rdData
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] laneMem [0:DEPTH-1];
            logic [7:0] laneRdReg;

            always_ff @(posedge clk) begin
                if (wrEn && byteEn[gi]) begin
                    laneMem[addr] <= wrData[gi*8 +: 8];
                end
                if (rdEn) begin
                    laneRdReg <= laneMem[addr];
                end
            end

            assign rdData[gi*8 +: 8] = laneRdReg;
        end
    endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage load/store responder with fixed wait states and a stall output.
// Optional misaligned-access trapping is enabled by defining MEM_ALIGN_CHECK_EN.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [31:0]       MemWriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        MemFunc,
    output logic [31:0]       MemReadData,
    output logic              MemReady,
    output logic              Stall,
    output logic              MisalignErr
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    memState_t         stateReg, stateNext;
    logic [3:0]        waitCntReg, waitCntNext;
    logic [ADDR_W-1:0] addrReg;
    logic [31:0]       dataReg;
    logic [2:0]        funcReg;
    logic              storeReg;
    logic              request;
    logic              misalign;
    logic [IDX_W-1:0]  wordIdx;
    logic [31:0]       bankRdData;
    logic              bankWrEn;

    assign request = MemRead | MemWrite;
    assign Stall   = request & ~MemReady;

    // Truncating the word field to the array depth makes out-of-range addresses wrap.
    assign wordIdx = IDX_W'(addrReg[ADDR_W-1:2]);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = isMisaligned(funcReg, addrReg[1:0]);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        stateNext   = stateReg;
        waitCntNext = waitCntReg;
        case (stateReg)
            IDLE: begin
                if (request) begin
                    if (WAIT_STATES > 0) begin
                        stateNext   = WAIT;
                        waitCntNext = WAIT_LOAD;
                    end else begin
                        stateNext = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (!request) begin
                    stateNext = IDLE;
                end else if (waitCntReg == 4'd0) begin
                    stateNext = ACCESS;
                end else begin
                    waitCntNext = waitCntReg - 4'd1;
                end
            end
            ACCESS:  stateNext = request ? DONE : IDLE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Write lands at the edge that ends ACCESS; an async reset before then cancels it.
    assign bankWrEn = (stateReg == ACCESS) && storeReg && !misalign;

    mem_bank #(
        .DEPTH     (DEPTH_WORDS),
        .ADDR_BITS (IDX_W)
    ) u_bank (
        .clk    (Clock),
        .rdEn   (stateReg == ACCESS),
        .wrEn   (bankWrEn),
        .byteEn (laneEnables(funcReg, addrReg[1:0])),
        .addr   (wordIdx),
        .wrData (storeLanes(funcReg, dataReg)),
        .rdData (bankRdData)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            stateReg    <= IDLE;
            waitCntReg  <= 4'd0;
            addrReg     <= '0;
            dataReg     <= '0;
            funcReg     <= FUNC_WD;
            storeReg    <= 1'b0;
            MemReadData <= '0;
            MemReady    <= 1'b0;
            MisalignErr <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            waitCntReg <= waitCntNext;
            if (stateReg == IDLE && request) begin
                addrReg  <= MemAddr;
                dataReg  <= MemWriteData;
                funcReg  <= MemFunc;
                storeReg <= MemWrite;
            end
            // Ready and load data are registered out of DONE, so they appear together.
            MemReady    <= (stateReg == DONE);
            MisalignErr <= (stateReg == DONE) && misalign;
            if (stateReg == DONE && !storeReg) begin
                MemReadData <= misalign ? 32'd0 : loadExtend(funcReg, addrReg[1:0], bankRdData);
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised self-checking bench for data_mem_ctrl against a byte-array model.
module tb_data_mem_ctrl;

    localparam int WS  = 2;
    localparam int LAT = WS + 3;   // posedges from driving a request to seeing MemReady
    localparam logic [2:0] F_BS = 3'b000;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HS = 3'b001;
    localparam logic [2:0] F_WD = 3'b010;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic [15:0] MemAddr = '0;
    logic [31:0] MemWriteData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  MemFunc = 3'b010;
    logic [31:0] MemReadData;
    logic        MemReady;
    logic        Stall;
    logic        MisalignErr;

    always #5 Clock = ~Clock;

    data_mem_ctrl #(
        .ADDR_W      (16),
        .DEPTH_WORDS (1024),
        .WAIT_STATES (WS)
    ) dut (
        .Clock        (Clock),
        .nReset       (nReset),
        .MemAddr      (MemAddr),
        .MemWriteData (MemWriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemFunc      (MemFunc),
        .MemReadData  (MemReadData),
        .MemReady     (MemReady),
        .Stall        (Stall),
        .MisalignErr  (MisalignErr)
    );

    int          assertCount = 0;
    int          failCount = 0;
    logic [7:0]  modelMem [0:63];
    logic [31:0] expReadData = '0;
    bit          readKnown = 1'b0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int accSize(input logic [2:0] f);
        if (f == 3'b000 || f == 3'b100) return 1;
        if (f == 3'b001 || f == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit misaligned(input logic [2:0] f, input logic [15:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return (int'(a) % accSize(f)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Byte address inside the 4 KiB array image, rounded down to the access size.
    function automatic int baseByte(input logic [2:0] f, input logic [15:0] a);
        int b;
        b = int'(a) % 4096;
        return b - (b % accSize(f));
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f, input logic [15:0] a);
        longint unsigned v;
        int sz;
        int b;
        v  = 0;
        sz = accSize(f);
        b  = baseByte(f, a);
        if (misaligned(f, a)) return 32'd0;
        for (int i = 0; i < sz; i++) v |= 64'(modelMem[b + i]) << (8 * i);
        if ((f == 3'b000 || f == 3'b001) && v[8 * sz - 1]) v |= ~((64'd1 << (8 * sz)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic modelStore(input logic [2:0] f, input logic [15:0] a, input logic [31:0] d);
        int b;
        b = baseByte(f, a);
        if (misaligned(f, a)) return;
        for (int i = 0; i < accSize(f); i++) modelMem[b + i] = d[8 * i +: 8];
    endtask

    task automatic waitReady(output int n, output bit stallOk);
        n = 0;
        stallOk = 1'b1;
        while (n < 30) begin
            @(posedge Clock);
            #1;
            n++;
            if (MemReady) break;
            if (!Stall) stallOk = 1'b0;
        end
    endtask

    task automatic runAccess(input string tag, input bit rd, input bit wr, input logic [2:0] f,
                             input logic [15:0] a, input logic [31:0] d);
        int          n;
        bit          stallOk;
        logic [31:0] expData;
        bit          expMis;
        expMis  = misaligned(f, a);
        expData = wr ? expReadData : modelLoad(f, a);
        $display("txn %s rd=%0d wr=%0d func=%0d addr=0x%04h wdata=0x%08h exp=0x%08h",
                 tag, rd, wr, f, a, d, expData);
        MemAddr = a; MemWriteData = d; MemFunc = f; MemRead = rd; MemWrite = wr;
        waitReady(n, stallOk);
        checkVal({tag, " latency"}, 32'(n), 32'(LAT));
        checkVal({tag, " stall"}, {31'b0, stallOk & ~Stall}, 32'd1);
        if (!wr || readKnown) checkVal({tag, " data"}, MemReadData, expData);
        checkVal({tag, " misalign"}, {31'b0, MisalignErr}, {31'b0, expMis});
        MemRead = 1'b0;
        MemWrite = 1'b0;
        if (wr) begin
            modelStore(f, a, d);
        end else begin
            expReadData = expData;
            readKnown = 1'b1;
        end
        @(posedge Clock);
        #1;
        checkVal({tag, " pulse"}, {31'b0, MemReady}, 32'd0);
    endtask

    initial begin
        int          n;
        bit          stallOk;
        bit          sawReady;
        logic [2:0]  f;
        logic [15:0] a;
        int          kind;

        // Reset with a load already requested.
        MemRead = 1'b1; MemFunc = F_WD; MemAddr = 16'h0100;
        repeat (3) @(posedge Clock);
        #1;
        checkVal("reset readdata", MemReadData, 32'd0);
        checkVal("reset ready", {31'b0, MemReady}, 32'd0);
        checkVal("reset stall", {31'b0, Stall}, 32'd1);
        nReset = 1'b1;
        $display("txn reset-load rd=1 addr=0x0100");
        waitReady(n, stallOk);
        checkVal("reset-load latency", 32'(n), 32'(LAT));
        checkVal("reset-load stall", {31'b0, stallOk}, 32'd1);
        MemRead = 1'b0;
        @(posedge Clock);
        #1;

        for (int w = 0; w < 16; w++) runAccess("prefill", 1'b0, 1'b1, F_WD, 16'(w * 4), $urandom);

        runAccess("st word", 1'b0, 1'b1, F_WD, 16'h0010, 32'h12345678);
        runAccess("ld bs", 1'b1, 1'b0, F_BS, 16'h0011, 32'h0);
        checkVal("plan bs", MemReadData, 32'h00000056);
        runAccess("ld bu", 1'b1, 1'b0, F_BU, 16'h0013, 32'h0);
        checkVal("plan bu", MemReadData, 32'h00000012);
        runAccess("ld hs", 1'b1, 1'b0, F_HS, 16'h0012, 32'h0);
        checkVal("plan hs", MemReadData, 32'h00001234);

        runAccess("clr word", 1'b0, 1'b1, F_WD, 16'h0020, 32'h0);
        runAccess("st bs", 1'b0, 1'b1, F_BS, 16'h0021, 32'hFFFFFF80);
        runAccess("ld word20", 1'b1, 1'b0, F_WD, 16'h0020, 32'h0);
        checkVal("plan word20", MemReadData, 32'h00008000);
        runAccess("ld bs21", 1'b1, 1'b0, F_BS, 16'h0021, 32'h0);
        checkVal("plan bs21", MemReadData, 32'hFFFFFF80);

        runAccess("rd+wr", 1'b1, 1'b1, F_WD, 16'h0004, 32'hA5A5A5A5);
        runAccess("ld word4", 1'b1, 1'b0, F_WD, 16'h0004, 32'h0);
        checkVal("plan word4", MemReadData, 32'hA5A5A5A5);

        // Store dropped while waiting: no completion, memory untouched.
        $display("txn abort wr=1 addr=0x0008");
        MemAddr = 16'h0008; MemWriteData = 32'hDEADBEEF; MemFunc = F_WD; MemWrite = 1'b1;
        repeat (2) begin @(posedge Clock); #1; end
        MemWrite = 1'b0;
        sawReady = 1'b0;
        repeat (8) begin
            @(posedge Clock);
            #1;
            if (MemReady) sawReady = 1'b1;
        end
        checkVal("abort ready", {31'b0, sawReady}, 32'd0);
        runAccess("abort readback", 1'b1, 1'b0, F_WD, 16'h0008, 32'h0);

        // Reset in the middle of a store loses the write.
        $display("txn reset-mid-store wr=1 addr=0x000c");
        MemAddr = 16'h000C; MemWriteData = 32'hCAFEF00D; MemFunc = F_WD; MemWrite = 1'b1;
        repeat (2) begin @(posedge Clock); #1; end
        nReset = 1'b0;
        MemWrite = 1'b0;
        #2;
        checkVal("midreset readdata", MemReadData, 32'd0);
        checkVal("midreset ready", {31'b0, MemReady}, 32'd0);
        @(posedge Clock);
        #1;
        nReset = 1'b1;
        expReadData = 32'd0;
        runAccess("midreset readback", 1'b1, 1'b0, F_WD, 16'h000C, 32'h0);

        runAccess("st misaligned", 1'b0, 1'b1, F_WD, 16'h0006, 32'h0BADF00D);
        runAccess("ld word4 again", 1'b1, 1'b0, F_WD, 16'h0004, 32'h0);
        runAccess("ld misaligned", 1'b1, 1'b0, F_HS, 16'h0013, 32'h0);

        // Request held across completion is taken as a new access.
        $display("txn back-to-back rd=1 addr=0x0010");
        MemAddr = 16'h0010; MemFunc = F_WD; MemRead = 1'b1;
        waitReady(n, stallOk);
        checkVal("b2b first latency", 32'(n), 32'(LAT));
        checkVal("b2b first data", MemReadData, modelLoad(F_WD, 16'h0010));
        waitReady(n, stallOk);
        checkVal("b2b period", 32'(n), 32'(WS + 3));
        MemRead = 1'b0;
        expReadData = modelLoad(F_WD, 16'h0010);
        @(posedge Clock);
        #1;

        for (int t = 0; t < 120; t++) begin
            f    = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 2);
            a    = 16'($urandom_range(0, 63)) | 16'($urandom_range(0, 15) << 12);
            runAccess("rand", kind != 1, kind != 0, f, a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
